timer_irq_status: RTL

- Consumer side of the two OPL2 interval timers.
- Decodes host writes to register 0x04 into per-timer start controls and mask bits.
- Latches timer overflow pulses into the FT1/FT2/IRQ status flags and drives an active-low IRQ.
- Serves host reads of the status register. Sits between the host register interface and the timer1/timer2 instances.

---
 rtl/timer_irq_status.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/timer_irq_status.sv
// -----------------------------------------------------------------------------
// timer_irq_status
//
// Consumer side of the two OPL2 interval timers. Decodes host writes to
// register 0x04 into per-timer run enables and mask bits, latches timer
// overflow pulses into the FT1/FT2 status flags, drives an active-low IRQ
// and answers host reads of the status register.
//
// Build option:
//   IRQ_CLEAR_ON_READ_EN  - when defined, a status read clears FT1/FT2 after
//                           the read value has been captured. An unmasked
//                           overflow in the read cycle still leaves its flag
//                           set. When undefined, reads have no side effects.
//
// Ports:
//   clk                    system clock
//   reset                  synchronous, active-high reset
//   reg04_wr               one-cycle strobe, host write to register 0x04
//   reg04_data[7:0]        write data: [7]=RST, [6]=MASK1, [5]=MASK2,
//                          [1]=ST2, [0]=ST1, [4:2] ignored
//   timer1_overflow_pulse  one-cycle overflow pulse from timer 1
//   timer2_overflow_pulse  one-cycle overflow pulse from timer 2
//   status_rd              one-cycle strobe, host status read
//   status_data[7:0]       {IRQ, FT1, FT2, STATUS_LOW_BITS}, registered
//   status_valid           one-cycle pulse, status_data was just updated
//   start_timer1           timer 1 run enable (ST1), registered level
//   start_timer2           timer 2 run enable (ST2), registered level
//   irq_n                  active-low interrupt, registered
// -----------------------------------------------------------------------------
module timer_irq_status #(
  parameter logic [4:0] STATUS_LOW_BITS = 5'b00110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reg04_wr,
  input  logic [7:0] reg04_data,
  input  logic       timer1_overflow_pulse,
  input  logic       timer2_overflow_pulse,
  input  logic       status_rd,
  output logic [7:0] status_data,
  output logic       status_valid,
  output logic       start_timer1,
  output logic       start_timer2,
  output logic       irq_n
);

  // Next value of a sticky flag: a set always beats a clear in the same
  // cycle, so an overflow arriving together with a clear is never lost.
  function automatic logic flag_next(input logic cur, input logic set,
                                     input logic clr);
    return set | (cur & ~clr);
  endfunction

  // State registers
  logic       ft1_r;
  logic       ft2_r;
  logic       mask1_r;
  logic       mask2_r;
  logic       start1_r;
  logic       start2_r;
  logic [7:0] status_r;
  logic       valid_r;
  logic       irq_n_r;

  // Next-state signals
  logic       wr_rst_s;
  logic       wr_cfg_s;
  logic       set1_s;
  logic       set2_s;
  logic       rd_clr_s;
  logic       ft1_view_s;
  logic       ft2_view_s;
  logic       ft1_nxt_s;
  logic       ft2_nxt_s;
  logic       mask1_nxt_s;
  logic       mask2_nxt_s;
  logic       start1_nxt_s;
  logic       start2_nxt_s;
  logic [7:0] status_nxt_s;
  logic       valid_nxt_s;
  logic       irq_n_nxt_s;

  // Bits 4:2 of register 0x04 carry no function in this block.
  logic       unused_data_s;
  assign unused_data_s = ^reg04_data[4:2];

  // Read-side flag clear, present only in the clear-on-read build.
  always_comb begin
    rd_clr_s = 1'b0;
`ifdef IRQ_CLEAR_ON_READ_EN
    if (status_rd) begin
      rd_clr_s = 1'b1;
    end else begin
      rd_clr_s = 1'b0;
    end
`else
    rd_clr_s = 1'b0;
`endif
  end

  // Register 0x04 decode, flag update, IRQ and status-read next state.
  always_comb begin
    wr_rst_s     = 1'b0;
    wr_cfg_s     = 1'b0;
    mask1_nxt_s  = mask1_r;
    mask2_nxt_s  = mask2_r;
    start1_nxt_s = start1_r;
    start2_nxt_s = start2_r;
    status_nxt_s = status_r;
    valid_nxt_s  = 1'b0;

    if (reg04_wr) begin
      if (reg04_data[7]) begin
        wr_rst_s = 1'b1;
      end else begin
        wr_cfg_s = 1'b1;
      end
    end else begin
      wr_rst_s = 1'b0;
      wr_cfg_s = 1'b0;
    end

    // Overflows are qualified by the mask held before any same-cycle write.
    set1_s = timer1_overflow_pulse & ~mask1_r;
    set2_s = timer2_overflow_pulse & ~mask2_r;

    // Flag values a read in this cycle reports (before any read clear).
    ft1_view_s = flag_next(ft1_r, set1_s, wr_rst_s);
    ft2_view_s = flag_next(ft2_r, set2_s, wr_rst_s);

    // Flag values actually stored, including the optional read clear.
    ft1_nxt_s = flag_next(ft1_r, set1_s, wr_rst_s | rd_clr_s);
    ft2_nxt_s = flag_next(ft2_r, set2_s, wr_rst_s | rd_clr_s);

    irq_n_nxt_s = ~(ft1_nxt_s | ft2_nxt_s);

    if (wr_cfg_s) begin
      mask1_nxt_s  = reg04_data[6];
      mask2_nxt_s  = reg04_data[5];
      start2_nxt_s = reg04_data[1];
      start1_nxt_s = reg04_data[0];
    end else begin
      mask1_nxt_s  = mask1_r;
      mask2_nxt_s  = mask2_r;
      start2_nxt_s = start2_r;
      start1_nxt_s = start1_r;
    end

    if (status_rd) begin
      status_nxt_s = {ft1_view_s | ft2_view_s, ft1_view_s, ft2_view_s,
                      STATUS_LOW_BITS};
      valid_nxt_s  = 1'b1;
    end else begin
      status_nxt_s = status_r;
      valid_nxt_s  = 1'b0;
    end
  end

  // State register bank; reset overrides every other event in the cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ft1_r    <= 1'b0;
      ft2_r    <= 1'b0;
      mask1_r  <= 1'b0;
      mask2_r  <= 1'b0;
      start1_r <= 1'b0;
      start2_r <= 1'b0;
      status_r <= {3'b000, STATUS_LOW_BITS};
      valid_r  <= 1'b0;
      irq_n_r  <= 1'b1;
    end else begin
      ft1_r    <= ft1_nxt_s;
      ft2_r    <= ft2_nxt_s;
      mask1_r  <= mask1_nxt_s;
      mask2_r  <= mask2_nxt_s;
      start1_r <= start1_nxt_s;
      start2_r <= start2_nxt_s;
      status_r <= status_nxt_s;
      valid_r  <= valid_nxt_s;
      irq_n_r  <= irq_n_nxt_s;
    end
  end

  assign status_data  = status_r;
  assign status_valid = valid_r;
  assign start_timer1 = start1_r;
  assign start_timer2 = start2_r;
  assign irq_n        = irq_n_r;

endmodule
